// File: rtl/keypad_matrix_emulator.sv
// Behavioural 4x4 membrane keypad: queued key codes are held down for HOLD_CYC
// cycles, then released for GAP_CYC cycles, answering the scanner's column strobes.
module keypad_matrix_emulator #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HOLD_CYC = 8,
    parameter int unsigned GAP_CYC  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   col,
    output logic [3:0]                   fila,
    input  logic [3:0]                   key_in,
    input  logic                         key_valid,
    output logic                         key_ready,
    output logic                         busy,
    output logic                         key_done,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         cur_key_q, cur_key_d;
    logic               key_done_q, key_done_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic [3:0]         mem_q [DEPTH];
    logic               push_c;
    logic               pop_c;
    logic [3:0]         key_col_c;
    logic [3:0]         key_row_c;

    // Next-state: FIFO bookkeeping and press/release sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_key_d  = cur_key_q;
        key_done_d = 1'b0;
        pop_c      = 1'b0;
        push_c     = key_valid && (count_q != LVL_W'(DEPTH));

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c     = 1'b1;
                    cur_key_d = mem_q[rd_ptr_q];
                    cnt_d     = CNT_W'(HOLD_CYC - 1);
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == '0) begin
                    key_done_d = 1'b1;
                    cnt_d      = CNT_W'(GAP_CYC - 1);
                    state_d    = RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (count_q != '0) begin
                    pop_c     = 1'b1;
                    cur_key_d = mem_q[rd_ptr_q];
                    cnt_d     = CNT_W'(HOLD_CYC - 1);
                    state_d   = PRESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_key_q  <= '0;
            key_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_key_q  <= cur_key_d;
            key_done_q <= key_done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= key_in;
        end
    end

    // Physical position of the held key on the membrane.
    always_comb begin
        key_col_c = 4'b0000;
        key_row_c = 4'b0000;
        case (cur_key_q)
            4'h1: begin key_col_c = 4'b0001; key_row_c = 4'b0001; end
            4'h4: begin key_col_c = 4'b0001; key_row_c = 4'b0010; end
            4'h7: begin key_col_c = 4'b0001; key_row_c = 4'b0100; end
            4'hF: begin key_col_c = 4'b0001; key_row_c = 4'b1000; end
            4'h2: begin key_col_c = 4'b0010; key_row_c = 4'b0001; end
            4'h5: begin key_col_c = 4'b0010; key_row_c = 4'b0010; end
            4'h8: begin key_col_c = 4'b0010; key_row_c = 4'b0100; end
            4'h0: begin key_col_c = 4'b0010; key_row_c = 4'b1000; end
            4'h3: begin key_col_c = 4'b0100; key_row_c = 4'b0001; end
            4'h6: begin key_col_c = 4'b0100; key_row_c = 4'b0010; end
            4'h9: begin key_col_c = 4'b0100; key_row_c = 4'b0100; end
            4'hE: begin key_col_c = 4'b0100; key_row_c = 4'b1000; end
            4'hA: begin key_col_c = 4'b1000; key_row_c = 4'b0001; end
            4'hB: begin key_col_c = 4'b1000; key_row_c = 4'b0010; end
            4'hC: begin key_col_c = 4'b1000; key_row_c = 4'b0100; end
            default: begin key_col_c = 4'b1000; key_row_c = 4'b1000; end
        endcase
    end

    // Rows answer the strobe in the same cycle; any non-matching column reads released.
    assign fila      = ((state_q == PRESS) && (col == key_col_c)) ? key_row_c : 4'b0000;
    assign key_ready = (count_q != LVL_W'(DEPTH));
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign key_done  = key_done_q;
    assign level     = count_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: a queue-based timeline model predicts
// every output, and a monitor checks replayed key order on each key_done pulse.
module tb_keypad_matrix_emulator;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned GAP   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col = 4'b0000;
    logic [3:0] fila;
    logic [3:0] key_in = 4'h0;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic       busy;
    logic       key_done;
    logic [2:0] level;

    keypad_matrix_emulator #(.DEPTH(DEPTH), .HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .fila(fila),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .busy(busy), .key_done(key_done), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // keymap[column index][row index] = key code printed on the membrane
    int keymap [4][4] = '{'{1, 4, 7, 15}, '{2, 5, 8, 0}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // Reference timeline: phase 0 idle, 1 held, 2 released; m_rem = cycles left in phase.
    int mq[$];
    int sb_q[$];
    int m_phase = 0;
    int m_rem = 0;
    int m_key = 0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            sb_q.delete();
            m_phase = 0;
            m_rem = 0;
            m_done = 1'b0;
        end else begin
            bit acc;
            acc = key_valid && (mq.size() < DEPTH);
            m_done = 1'b0;
            case (m_phase)
                0: if (mq.size() > 0) begin
                    m_key = mq.pop_front(); m_phase = 1; m_rem = HOLD;
                end
                1: if (m_rem == 1) begin
                    m_phase = 2; m_rem = GAP; m_done = 1'b1;
                end else m_rem--;
                default: if (m_rem == 1) begin
                    if (mq.size() > 0) begin
                        m_key = mq.pop_front(); m_phase = 1; m_rem = HOLD;
                    end else m_phase = 0;
                end else m_rem--;
            endcase
            if (acc) begin
                mq.push_back(int'(key_in));
                sb_q.push_back(int'(key_in));
            end
        end
    end

    function automatic int exp_fila();
        logic [3:0] cb;
        logic [3:0] rb;
        if (m_phase != 1) return 0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                cb = 4'b0001 << c;
                rb = 4'b0001 << r;
                if (keymap[c][r] == m_key && col == cb) return int'(rb);
            end
        end
        return 0;
    endfunction

    // Scanner: rotating one-hot strobe unless a directed test overrides it.
    bit         force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;
    logic [3:0] rot = 4'b0001;

    always @(negedge clk) begin
        if (force_en) begin
            col = force_val;
        end else begin
            col = rot;
            rot = {rot[2:0], rot[3]};
        end
    end

    // Monitor: per-cycle output checks plus in-order key replay on key_done.
    int seen_key = -1;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            seen_key = -1;
        end else begin
            chk("fila", int'(fila), exp_fila());
            chk("level", int'(level), mq.size());
            chk("key_ready", int'(key_ready), int'(mq.size() < DEPTH));
            chk("busy", int'(busy), int'((m_phase != 0) || (mq.size() != 0)));
            chk("key_done", int'(key_done), int'(m_done));
            if (fila != 4'b0000) begin
                seen_key = -2;
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        if (col == (4'b0001 << c) && fila == (4'b0001 << r)) seen_key = keymap[c][r];
                    end
                end
            end
            if (key_done) begin
                if (sb_q.size() == 0) begin
                    timeout("scoreboard_underflow");
                end else begin
                    chk("key_order", seen_key, sb_q.pop_front());
                end
                seen_key = -1;
            end
        end
    end

    // Called at a negedge; holds key_valid until the FIFO has room, then drops it.
    task automatic push_key(input int k);
        int n;
        n = 0;
        key_in = 4'(k);
        key_valid = 1'b1;
        while (!key_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("push_wait");
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_phase != 0 || mq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout("drain");
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
    endtask

    task automatic wait_press();
        int n;
        n = 0;
        while (m_phase != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout("wait_press");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_fila", int'(fila), 0);
        chk("rst_key_ready", int'(key_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_key_done", int'(key_done), 0);
        chk("rst_level", int'(level), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single key 0x5 held then released
        push_key(5);
        drain();

        // Every code through the key map
        for (int k = 0; k < 16; k++) push_key(k);
        drain();

        // Five back-to-back keys against a four-deep FIFO
        for (int k = 0; k < 5; k++) push_key((k * 7 + 3) % 16);
        drain();

        // Idle and non-one-hot strobes while 0x1 is held
        push_key(1);
        wait_press();
        repeat (2) @(negedge clk);
        @(posedge clk);
        force_en = 1'b1;
        force_val = 4'b0000;
        @(posedge clk);
        force_val = 4'b0011;
        @(posedge clk);
        force_en = 1'b0;
        drain();

        // Asynchronous reset mid-press with two keys still queued
        push_key(5);
        push_key(9);
        push_key(12);
        wait_press();
        @(posedge clk);
        force_en = 1'b1;
        force_val = 4'b0010;
        @(negedge clk);
        #2;
        chk("pre_reset_fila", int'(fila), 2);
        rst_n = 1'b0;
        #1;
        chk("reset_fila", int'(fila), 0);
        chk("reset_level", int'(level), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_key_done", int'(key_done), 0);
        force_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        // Push on the same edge the idle FSM pops the only entry
        push_key(3);
        push_key(9);
        drain();

        // Randomized traffic, valid independent of ready
        for (int i = 0; i < 400; i++) begin
            key_valid = ($urandom_range(0, 2) == 0);
            key_in = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        key_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
